// File: rtl/mmm_sa_pkg.sv
// Shared constants and types for the 2x2 posit<4,0> systolic-array wrapper.
// Feeder FSM state and the framing bit offsets of the wrapper input word.
package mmm_sa_pkg;

  localparam int POSIT_WIDTH = 4;
  localparam int N           = 2;
  localparam int M           = 2;
  localparam int SOB_BIT     = (N + M) * POSIT_WIDTH;
  localparam int EOB_BIT     = SOB_BIT + 1;
  localparam int DATA_W      = EOB_BIT + 1;
  localparam int DRAIN_LEN   = ((N > M) ? N : M) - 1;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } feeder_state_t;

endpackage

// File: rtl/skew_line.sv
// Zero-reset delay line of DEPTH stages; DEPTH=0 is a plain wire.
// Used to apply the per-lane diagonal skew in front of the array.
module skew_line #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_pass
    logic unused_clk;
    assign unused_clk = clk ^ rst_n;
    assign q = d;
  end else begin : g_sr
    logic [WIDTH-1:0] sr [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
      end else begin
        sr[0] <= d;
        for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
    end

    assign q = sr[DEPTH-1];
  end

endmodule

// File: rtl/sa_feeder.sv
// Upstream feeder: skews A/B k-slices per lane and frames blocks with SOB/EOB.
// One slot register feeds the skew lines; the output word is registered.
module sa_feeder
  import mmm_sa_pkg::*;
#(
  parameter int POSIT_WIDTH = mmm_sa_pkg::POSIT_WIDTH,
  parameter int N           = mmm_sa_pkg::N,
  parameter int M           = mmm_sa_pkg::M,
  parameter int KCNT_W      = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [N*POSIT_WIDTH-1:0]        s_a,
  input  logic [M*POSIT_WIDTH-1:0]        s_b,
  input  logic                            s_last,
  output logic                            valid_o,
  output logic [(N+M)*POSIT_WIDTH+1:0]    data_o,
  output logic                            busy_o,
  output logic [KCNT_W-1:0]               k_count_o
);

  localparam int PW   = POSIT_WIDTH;
  localparam int AW   = N * PW;
  localparam int BW   = M * PW;
  localparam int DLEN = ((N > M) ? N : M) - 1;
  localparam int DCW  = (DLEN > 1) ? $clog2(DLEN) : 1;
  localparam logic [KCNT_W-1:0] KMAX = '1;

  feeder_state_t state, state_nx;
  logic [DCW-1:0]    drain_cnt;
  logic [KCNT_W-1:0] cnt, cnt_nx;

  logic          take;
  logic          push_vld, push_sob, push_eob;
  logic [AW-1:0] push_a;
  logic [BW-1:0] push_b;

  logic          slot_vld, slot_sob, slot_eob;
  logic [AW-1:0] slot_a, a_sk;
  logic [BW-1:0] slot_b, b_sk;

  assign s_ready = (state != DRAIN);
  assign take    = s_valid && s_ready;
  assign cnt_nx  = (cnt == KMAX) ? cnt : cnt + 1'b1;

  always_comb begin
    state_nx = state;
    push_vld = 1'b0;
    push_sob = 1'b0;
    push_eob = 1'b0;
    push_a   = '0;
    push_b   = '0;
    unique case (state)
      IDLE: begin
        if (take) begin
          push_vld = 1'b1;
          push_sob = 1'b1;
          push_eob = s_last;
          push_a   = s_a;
          push_b   = s_b;
          state_nx = !s_last ? STREAM : (DLEN == 0) ? IDLE : DRAIN;
        end
      end
      STREAM: begin
        // bubbles still push a zero slot to keep lanes aligned
        push_vld = 1'b1;
        if (take) begin
          push_eob = s_last;
          push_a   = s_a;
          push_b   = s_b;
          if (s_last) state_nx = (DLEN == 0) ? IDLE : DRAIN;
        end
      end
      DRAIN: begin
        push_vld = 1'b1;
        if (drain_cnt == DCW'(DLEN - 1)) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      drain_cnt <= '0;
      cnt       <= '0;
      busy_o    <= 1'b0;
      k_count_o <= '0;
      slot_vld  <= 1'b0;
      slot_sob  <= 1'b0;
      slot_eob  <= 1'b0;
      slot_a    <= '0;
      slot_b    <= '0;
      valid_o   <= 1'b0;
      data_o    <= '0;
    end else begin
      state     <= state_nx;
      busy_o    <= (state_nx != IDLE);
      drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
      if (state == IDLE && take) cnt <= KCNT_W'(1);
      else if (state == STREAM)  cnt <= cnt_nx;
      if (push_eob) k_count_o <= (state == IDLE) ? KCNT_W'(1) : cnt_nx;
      slot_vld  <= push_vld;
      slot_sob  <= push_sob;
      slot_eob  <= push_eob;
      slot_a    <= push_a;
      slot_b    <= push_b;
      valid_o   <= slot_vld;
      data_o    <= slot_vld ? {slot_eob, slot_sob, b_sk, a_sk} : '0;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_a
    skew_line #(.WIDTH(PW), .DEPTH(i)) u_skew (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (slot_a[i*PW +: PW]),
      .q     (a_sk[i*PW +: PW])
    );
  end

  for (genvar j = 0; j < M; j++) begin : g_b
    skew_line #(.WIDTH(PW), .DEPTH(j)) u_skew (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (slot_b[j*PW +: PW]),
      .q     (b_sk[j*PW +: PW])
    );
  end

endmodule

// File: tb/tb_sa_feeder.sv
// Directed bench for sa_feeder: framing, skew, bubbles, drain, reset, saturation.
// Outputs are logged 2ns after each rising edge; inputs change on falling edges.
`timescale 1ns/1ps
module tb_sa_feeder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_a = '0;
  logic [7:0]  s_b = '0;
  logic        s_last = 1'b0;
  logic        s_ready, valid_o, busy_o;
  logic [17:0] data_o;
  logic [15:0] k_count_o;

  logic        sat_ready, sat_valid, sat_busy;
  logic [17:0] sat_data;
  logic [3:0]  sat_k;

  int n_chk = 0;
  int n_pass = 0;

  logic        log_en = 1'b0;
  int          log_n = 0;
  logic        vlog [64];
  logic        rlog [64];
  logic        blog [64];
  logic [17:0] dlog [64];
  logic [17:0] exp_d [32];

  always #5 clk = ~clk;

  sa_feeder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_a       (s_a),
    .s_b       (s_b),
    .s_last    (s_last),
    .valid_o   (valid_o),
    .data_o    (data_o),
    .busy_o    (busy_o),
    .k_count_o (k_count_o)
  );

  sa_feeder #(.KCNT_W(4)) u_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (sat_ready),
    .s_a       (s_a),
    .s_b       (s_b),
    .s_last    (s_last),
    .valid_o   (sat_valid),
    .data_o    (sat_data),
    .busy_o    (sat_busy),
    .k_count_o (sat_k)
  );

  always @(posedge clk) begin
    #2;
    if (log_en && log_n < 64) begin
      vlog[log_n] = valid_o;
      rlog[log_n] = s_ready;
      blog[log_n] = busy_o;
      dlog[log_n] = data_o;
      log_n++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic beat(input logic [7:0] a, input logic [7:0] b,
                      input logic last);
    @(negedge clk);
    s_valid = 1'b1;
    s_a     = a;
    s_b     = b;
    s_last  = last;
  endtask

  task automatic idle_cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_a     = '0;
      s_b     = '0;
    end
  endtask

  task automatic begin_log();
    log_n  = 0;
    log_en = 1'b1;
  endtask

  task automatic clear_exp();
    for (int t = 0; t < 32; t++) exp_d[t] = '0;
  endtask

  // valid must be high exactly on log slots 1..nv with data exp_d[t]
  task automatic chk_block(input string tag, input int nv);
    for (int t = 0; t <= nv + 1; t++) begin
      check($sformatf("%s valid[%0d]", tag, t), 32'(vlog[t]),
            32'((t >= 1) && (t <= nv)));
      check($sformatf("%s data[%0d]", tag, t), 32'(dlog[t]),
            ((t >= 1) && (t <= nv)) ? 32'(exp_d[t]) : 32'd0);
    end
  endtask

  initial begin
    // reset state
    #1;
    check("rst valid", 32'(valid_o), 0);
    check("rst data", 32'(data_o), 0);
    check("rst busy", 32'(busy_o), 0);
    check("rst kcnt", 32'(k_count_o), 0);
    idle_cyc(2);
    rst_n = 1'b1;
    idle_cyc(1);
    check("rel ready", 32'(s_ready), 1);

    // single beat block, K=1
    clear_exp();
    exp_d[1] = 18'h30301;
    exp_d[2] = 18'h04020;
    beat(8'h21, 8'h43, 1'b1);
    begin_log();
    idle_cyc(8);
    chk_block("k1", 2);
    check("k1 ready0", 32'(rlog[0]), 0);
    check("k1 ready1", 32'(rlog[1]), 1);
    check("k1 busy0", 32'(blog[0]), 1);
    check("k1 busy1", 32'(blog[1]), 0);
    check("k1 kcnt", 32'(k_count_o), 1);

    // K=3 back-to-back
    clear_exp();
    exp_d[1] = 18'h10501;
    exp_d[2] = 18'h05612;
    exp_d[3] = 18'h26723;
    exp_d[4] = 18'h07030;
    beat(8'h11, 8'h55, 1'b0);
    begin_log();
    beat(8'h22, 8'h66, 1'b0);
    beat(8'h33, 8'h77, 1'b1);
    idle_cyc(8);
    chk_block("k3", 4);
    check("k3 kcnt", 32'(k_count_o), 3);

    // K=3 with a bubble at k=1
    clear_exp();
    exp_d[1] = 18'h10501;
    exp_d[2] = 18'h05010;
    exp_d[3] = 18'h00602;
    exp_d[4] = 18'h26723;
    exp_d[5] = 18'h07030;
    beat(8'h11, 8'h55, 1'b0);
    begin_log();
    idle_cyc(1);
    beat(8'h22, 8'h66, 1'b0);
    beat(8'h33, 8'h77, 1'b1);
    idle_cyc(8);
    chk_block("bub", 5);
    check("bub kcnt", 32'(k_count_o), 4);

    // s_valid held through DRAIN, next block follows with no gap
    clear_exp();
    exp_d[1] = 18'h30301;
    exp_d[2] = 18'h04020;
    exp_d[3] = 18'h30705;
    exp_d[4] = 18'h08060;
    beat(8'h21, 8'h43, 1'b1);
    begin_log();
    beat(8'h65, 8'h87, 1'b1);
    beat(8'h65, 8'h87, 1'b1);
    idle_cyc(8);
    chk_block("b2b", 4);
    check("b2b ready0", 32'(rlog[0]), 0);
    check("b2b ready1", 32'(rlog[1]), 1);
    check("b2b ready2", 32'(rlog[2]), 0);
    check("b2b ready3", 32'(rlog[3]), 1);

    // reset in mid-STREAM
    beat(8'h11, 8'h55, 1'b0);
    beat(8'h22, 8'h66, 1'b0);
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    check("mid busy", 32'(busy_o), 1);
    check("mid valid", 32'(valid_o), 1);
    rst_n = 1'b0;
    #1;
    check("arst valid", 32'(valid_o), 0);
    check("arst data", 32'(data_o), 0);
    check("arst busy", 32'(busy_o), 0);
    check("arst kcnt", 32'(k_count_o), 0);
    idle_cyc(1);
    rst_n = 1'b1;
    idle_cyc(1);
    check("post ready", 32'(s_ready), 1);
    check("post busy", 32'(busy_o), 0);
    check("post valid", 32'(valid_o), 0);
    clear_exp();
    exp_d[1] = 18'h30301;
    exp_d[2] = 18'h04020;
    beat(8'h21, 8'h43, 1'b1);
    begin_log();
    idle_cyc(8);
    chk_block("post", 2);
    check("post kcnt", 32'(k_count_o), 1);

    // 18-beat block: 16-bit counter exact, 4-bit counter saturates
    clear_exp();
    exp_d[1] = 18'h10101;
    for (int t = 2; t <= 17; t++) exp_d[t] = 18'h01111;
    exp_d[18] = 18'h21111;
    exp_d[19] = 18'h01010;
    beat(8'h11, 8'h11, 1'b0);
    begin_log();
    for (int k = 1; k < 18; k++) beat(8'h11, 8'h11, 1'(k == 17));
    idle_cyc(8);
    chk_block("sat", 19);
    check("sat kcnt16", 32'(k_count_o), 18);
    check("sat kcnt4", 32'(sat_k), 15);
    check("sat valid4", 32'(sat_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
